regfile_wb_ctrl: RTL and testbench

REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

---
 rtl/rv32_pkg.sv | 33 +++
 rtl/regfile_wb_ctrl_load_extend.sv | 40 ++++
 rtl/regfile_wb_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// rv32_pkg
// Shared RV32 definitions used by the decoder, the register file and the
// write-back controller: datapath width default, load funct3 encodings,
// the pending-load queue entry layout and the write-port source select.
package rv32_pkg;

  localparam int XLEN_DEFAULT = 32;

  // RV32I load funct3 encodings
  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_funct3_e;

  // One outstanding load: where it goes and how to slice the returned word
  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [1:0] off;
  } lq_entry_t;

  // Which producer owns the register-file write port this cycle
  typedef enum logic [1:0] {
    WSRC_NONE = 2'd0,
    WSRC_LOAD = 2'd1,
    WSRC_SKID = 2'd2,
    WSRC_ALU  = 2'd3
  } wsrc_e;

endpackage

// File: rtl/regfile_wb_ctrl_load_extend.sv
// load_extend
// Combinational extraction of a load result from the raw aligned memory word.
// Ports:
//   funct3  - load type
//   off     - byte offset within the word (halfword lane uses off[1])
//   word    - raw aligned word from memory
//   data    - extended result (0 for an unknown load type)
//   illegal - funct3 is not a load encoding
module load_extend
  import rv32_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] data,
  output logic            illegal
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  // Lanes are picked from the low 32 bits; wider XLEN only widens the extension
  always_comb begin
    byteLane = word[{off, 3'b000} +: 8];
    halfLane = word[{off[1], 4'b0000} +: 16];
    data     = '0;
    illegal  = 1'b0;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){byteLane[7]}}, byteLane};
      F3_LH:   data = {{(XLEN-16){halfLane[15]}}, halfLane};
      F3_LW:   data = word;
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byteLane};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, halfLane};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl
// Register-file write-back controller. Merges in-order load responses and
// ALU results onto a single registered write port. Loads wait in a small
// flip-flop FIFO; an ALU result that loses the port to a load is parked in a
// one-entry skid register and upstream is stalled until it drains.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data   - ALU/jump result
//   ld_issue_*                  - load issue (rd, funct3, offset), ready back
//   mem_rsp_valid/mem_rsp_data  - in-order load data from memory
//   wr_en/wr_addr/wr_data       - registered register-file write port
//   busy_mask                   - registers with a pending load
//   stall                       - upstream must hold ALU result
//   err_rsp                     - pulse: stray response or illegal funct3
module regfile_wb_ctrl
  import rv32_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int LQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_issue_valid,
  input  logic [4:0]      ld_issue_rd,
  input  logic [2:0]      ld_issue_funct3,
  input  logic [1:0]      ld_issue_off,
  output logic            ld_issue_ready,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            wr_en,
  output logic [4:0]      wr_addr,
  output logic [XLEN-1:0] wr_data,
  output logic [31:0]     busy_mask,
  output logic            stall,
  output logic            err_rsp
);

  localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CW = $clog2(LQ_DEPTH + 1);

  lq_entry_t             lq_q [LQ_DEPTH];
  logic [LQ_DEPTH-1:0]   lqValid_q, lqValid_d;
  logic [PW-1:0]         wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0]         count_q, count_d;

  logic                  skidFull_q, skidFull_d;
  logic [4:0]            skidRd_q, skidRd_d;
  logic [XLEN-1:0]       skidData_q, skidData_d;

  logic                  wrEn_q, wrEn_d;
  logic [4:0]            wrAddr_q, wrAddr_d;
  logic [XLEN-1:0]       wrData_q, wrData_d;
  logic                  errRsp_q, errRsp_d;

  logic                  push, pop, aluAccept, lqEmpty;
  lq_entry_t             head;
  logic [XLEN-1:0]       ldData;
  logic                  ldIllegal;
  wsrc_e                 wsrc;
  logic [4:0]            selRd;
  logic [XLEN-1:0]       selData;

  // Pointer advance with explicit wrap so any depth behaves modulo LQ_DEPTH
  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    if (p == PW'(LQ_DEPTH - 1)) return '0;
    else return p + PW'(1);
  endfunction

  assign lqEmpty        = (count_q == '0);
  assign ld_issue_ready = (count_q < CW'(LQ_DEPTH));
  assign push           = ld_issue_valid && ld_issue_ready;
  assign pop            = mem_rsp_valid && !lqEmpty;
  assign stall          = skidFull_q;
  assign aluAccept      = alu_valid && !skidFull_q;
  assign head           = lq_q[rdPtr_q];

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .funct3  (head.funct3),
    .off     (head.off),
    .word    (mem_rsp_data),
    .data    (ldData),
    .illegal (ldIllegal)
  );

  // Queue bookkeeping; ready is based on the current count, so a full queue
  // never pushes even if it pops in the same cycle
  always_comb begin
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    count_d   = count_q;
    lqValid_d = lqValid_q;
    if (pop) begin
      lqValid_d[rdPtr_q] = 1'b0;
      rdPtr_d            = nextPtr(rdPtr_q);
    end
    if (push) begin
      lqValid_d[wrPtr_q] = 1'b1;
      wrPtr_d            = nextPtr(wrPtr_q);
    end
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // Write-port arbitration: load pop, then skid, then the live ALU result.
  // A skid-full cycle never accepts ALU input, so ALU only wins when idle.
  always_comb begin
    wsrc       = WSRC_NONE;
    selRd      = '0;
    selData    = '0;
    skidFull_d = skidFull_q;
    skidRd_d   = skidRd_q;
    skidData_d = skidData_q;
    if (pop) begin
      wsrc    = WSRC_LOAD;
      selRd   = head.rd;
      selData = ldData;
      if (aluAccept) begin
        skidFull_d = 1'b1;
        skidRd_d   = alu_rd;
        skidData_d = alu_data;
      end
    end else if (skidFull_q) begin
      wsrc       = WSRC_SKID;
      selRd      = skidRd_q;
      selData    = skidData_q;
      skidFull_d = 1'b0;
    end else if (aluAccept) begin
      wsrc    = WSRC_ALU;
      selRd   = alu_rd;
      selData = alu_data;
    end
  end

  // Writes to x0 still consume their slot but never reach the register file
  always_comb begin
    wrEn_d   = (wsrc != WSRC_NONE) && (selRd != 5'd0);
    wrAddr_d = wrEn_d ? selRd : wrAddr_q;
    wrData_d = wrEn_d ? selData : wrData_q;
    errRsp_d = (mem_rsp_valid && lqEmpty) || (pop && ldIllegal);
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (lqValid_q[i]) busy_mask[lq_q[i].rd] = 1'b1;
    end
    busy_mask[0] = 1'b0;
  end

  // State registers; reset drops pending loads and skid content silently
  always_ff @(posedge clk) begin
    if (reset) begin
      lqValid_q  <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      skidFull_q <= 1'b0;
      skidRd_q   <= '0;
      skidData_q <= '0;
      wrEn_q     <= 1'b0;
      wrAddr_q   <= '0;
      wrData_q   <= '0;
      errRsp_q   <= 1'b0;
    end else begin
      lqValid_q  <= lqValid_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      skidFull_q <= skidFull_d;
      skidRd_q   <= skidRd_d;
      skidData_q <= skidData_d;
      wrEn_q     <= wrEn_d;
      wrAddr_q   <= wrAddr_d;
      wrData_q   <= wrData_d;
      errRsp_q   <= errRsp_d;
    end
  end

  // Queue payload needs no reset; validity is tracked by lqValid_q
  always_ff @(posedge clk) begin
    if (push) lq_q[wrPtr_q] <= '{rd: ld_issue_rd, funct3: ld_issue_funct3, off: ld_issue_off};
  end

  assign wr_en   = wrEn_q;
  assign wr_addr = wrAddr_q;
  assign wr_data = wrData_q;
  assign err_rsp = errRsp_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl
// Directed bench for regfile_wb_ctrl. Inputs change and outputs are sampled
// 1 time unit after each rising edge.
module tb_regfile_wb_ctrl;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_issue_valid;
  logic [4:0]      ld_issue_rd;
  logic [2:0]      ld_issue_funct3;
  logic [1:0]      ld_issue_off;
  logic            ld_issue_ready;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_data;
  logic            wr_en;
  logic [4:0]      wr_addr;
  logic [XLEN-1:0] wr_data;
  logic [31:0]     busy_mask;
  logic            stall;
  logic            err_rsp;

  int total = 0;
  int bad   = 0;

  regfile_wb_ctrl #(.XLEN(XLEN), .LQ_DEPTH(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .alu_valid       (alu_valid),
    .alu_rd          (alu_rd),
    .alu_data        (alu_data),
    .ld_issue_valid  (ld_issue_valid),
    .ld_issue_rd     (ld_issue_rd),
    .ld_issue_funct3 (ld_issue_funct3),
    .ld_issue_off    (ld_issue_off),
    .ld_issue_ready  (ld_issue_ready),
    .mem_rsp_valid   (mem_rsp_valid),
    .mem_rsp_data    (mem_rsp_data),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .busy_mask       (busy_mask),
    .stall           (stall),
    .err_rsp         (err_rsp)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ldV, input logic [4:0] ldRd, input logic [2:0] f3,
                               input logic [1:0] off, input logic rspV, input logic [31:0] rspD,
                               input logic aluV, input logic [4:0] aRd, input logic [31:0] aD);
    ld_issue_valid  = ldV;
    ld_issue_rd     = ldRd;
    ld_issue_funct3 = f3;
    ld_issue_off    = off;
    mem_rsp_valid   = rspV;
    mem_rsp_data    = rspD;
    alu_valid       = aluV;
    alu_rd          = aRd;
    alu_data        = aD;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic checkWrite(input string tag, input logic en, input logic [4:0] addr, input logic [31:0] data);
    checkOutput({tag, ".wr_en"}, {31'd0, wr_en}, {31'd0, en});
    if (en) begin
      checkOutput({tag, ".wr_addr"}, {27'd0, wr_addr}, {27'd0, addr});
      checkOutput({tag, ".wr_data"}, wr_data, data);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick();
    tick();
    checkOutput("rst.wr_en",   {31'd0, wr_en}, 32'd0);
    checkOutput("rst.wr_addr", {27'd0, wr_addr}, 32'd0);
    checkOutput("rst.wr_data", wr_data, 32'd0);
    checkOutput("rst.stall",   {31'd0, stall}, 32'd0);
    checkOutput("rst.err",     {31'd0, err_rsp}, 32'd0);
    checkOutput("rst.busy",    busy_mask, 32'd0);
    checkOutput("rst.ready",   {31'd0, ld_issue_ready}, 32'd1);
    reset = 1'b0;

    // LB x5 off=3
    applyStimulus(1, 5, 3'b000, 3, 0, 0, 0, 0, 0);
    tick();
    checkOutput("lb.busy", busy_mask, 32'h0000_0020);
    applyStimulus(0, 0, 0, 0, 1, 32'h80FF_1234, 0, 0, 0);
    tick();
    checkWrite("lb", 1, 5, 32'hFFFF_FF80);
    checkOutput("lb.busy_clr", busy_mask, 32'd0);

    // LHU x6 off=2, busy held while waiting
    applyStimulus(1, 6, 3'b101, 2, 0, 0, 0, 0, 0);
    tick();
    checkOutput("lhu.busy0", busy_mask, 32'h0000_0040);
    idle();
    tick();
    checkOutput("lhu.busy1", busy_mask, 32'h0000_0040);
    checkOutput("lhu.idle_wr", {31'd0, wr_en}, 32'd0);
    applyStimulus(0, 0, 0, 0, 1, 32'h8001_0000, 0, 0, 0);
    tick();
    checkWrite("lhu", 1, 6, 32'h0000_8001);
    checkOutput("lhu.busy_clr", busy_mask, 32'd0);

    // Load pop collides with ALU x7
    applyStimulus(1, 9, 3'b010, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("col.stall0", {31'd0, stall}, 32'd0);
    applyStimulus(0, 0, 0, 0, 1, 32'h1234_5678, 1, 7, 32'h11);
    tick();
    checkWrite("col.load", 1, 9, 32'h1234_5678);
    checkOutput("col.stall1", {31'd0, stall}, 32'd1);
    idle();
    tick();
    checkWrite("col.alu", 1, 7, 32'h11);
    checkOutput("col.stall2", {31'd0, stall}, 32'd0);
    tick();
    checkOutput("col.after", {31'd0, wr_en}, 32'd0);

    // Fill queue, third issue dropped, in-order responses
    applyStimulus(1, 10, 3'b001, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 11, 3'b100, 1, 0, 0, 0, 0, 0);
    tick();
    checkOutput("full.ready", {31'd0, ld_issue_ready}, 32'd0);
    checkOutput("full.busy", busy_mask, 32'h0000_0C00);
    applyStimulus(1, 12, 3'b010, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("full.busy_drop", busy_mask, 32'h0000_0C00);
    applyStimulus(0, 0, 0, 0, 1, 32'h0000_8000, 0, 0, 0);
    tick();
    checkWrite("full.r0", 1, 10, 32'hFFFF_8000);
    checkOutput("full.ready1", {31'd0, ld_issue_ready}, 32'd1);
    applyStimulus(0, 0, 0, 0, 1, 32'h0000_AB00, 0, 0, 0);
    tick();
    checkWrite("full.r1", 1, 11, 32'h0000_00AB);
    checkOutput("full.busy_clr", busy_mask, 32'd0);
    checkOutput("full.err0", {31'd0, err_rsp}, 32'd0);

    // Stray response: queue empty
    applyStimulus(0, 0, 0, 0, 1, 32'hCAFE_0000, 0, 0, 0);
    tick();
    checkOutput("stray.err", {31'd0, err_rsp}, 32'd1);
    checkOutput("stray.wr_en", {31'd0, wr_en}, 32'd0);
    idle();
    tick();
    checkOutput("stray.err_pulse", {31'd0, err_rsp}, 32'd0);

    // ALU to x0 never writes
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 32'h0000_DEAD);
    tick();
    checkOutput("x0.wr_en", {31'd0, wr_en}, 32'd0);

    // ALU write to a busy register proceeds immediately
    applyStimulus(1, 20, 3'b010, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 20, 32'h55);
    tick();
    checkWrite("waw", 1, 20, 32'h55);
    checkOutput("waw.busy", busy_mask, 32'h0010_0000);
    applyStimulus(0, 0, 0, 0, 1, 32'h0000_0077, 0, 0, 0);
    tick();
    checkWrite("waw.load", 1, 20, 32'h77);

    // Illegal funct3 writes zero and flags
    applyStimulus(1, 13, 3'b011, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, 0);
    tick();
    checkWrite("ill", 1, 13, 32'h0);
    checkOutput("ill.err", {31'd0, err_rsp}, 32'd1);

    // Reset with two loads pending
    applyStimulus(1, 14, 3'b010, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 15, 3'b010, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("mrst.busy0", busy_mask, 32'h0000_C000);
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("mrst.busy", busy_mask, 32'd0);
    checkOutput("mrst.wr_en", {31'd0, wr_en}, 32'd0);
    checkOutput("mrst.ready", {31'd0, ld_issue_ready}, 32'd1);
    applyStimulus(0, 0, 0, 0, 1, 32'h1111_2222, 0, 0, 0);
    tick();
    checkOutput("mrst.err", {31'd0, err_rsp}, 32'd1);
    checkOutput("mrst.nowr", {31'd0, wr_en}, 32'd0);
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
